fft8_frame_sequencer: RTL and testbench
=======================================

# fft8_frame_sequencer

Streaming front/back end for the 8-point, 16-bit FFT core (`FFT_8point_16bit`). Accepts real samples one per handshake, assembles a frame of 8, presents it in parallel to the core, waits the core latency, captures the 8 complex bins and streams them out one per handshake. Sits between the sample source and the result consumer; the FFT core instance is outside this block.

## Interface

Parameters:

- `W`, 16: sample/bin width (two's complement).
- `FFT_LAT`, 3: core latency in clocks from stable `x*` with `en`=1 to valid `r*`/`i*`; legal range 1..15.

Ports:

- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset (asserted at 0).
- `in_valid`, input, 1: sample present.
- `in_ready`, output, 1: block can accept a sample.
- `in_data`, input, W: real sample.
- `out_valid`, output, 1: bin present.
- `out_ready`, input, 1: consumer accepts bin.
- `out_re`, output, W: bin real part.
- `out_im`, output, W: bin imaginary part.
- `out_idx`, output, 3: bin index 0..7.
- `out_last`, output, 1: high with bin 7.
- `flush`, input, 1: synchronous abort of a partial frame (FILL only).
- `fft_x0`..`fft_x7`, output, W each: core inputs.
- `fft_en`, output, 1: core enable.
- `fft_r0`..`fft_r7`, `fft_i0`..`fft_i7`, input, W each: core outputs.
- `busy`, output, 1: high in COMPUTE or DRAIN.
- `frame_cnt`, output, 16: completed frames, wraps 0xFFFF→0.

## Operation

- FSM: FILL → COMPUTE → DRAIN → FILL. Reset state is FILL.
- FILL:
  - `in_ready`=1.
  - Each `in_valid&&in_ready` writes `in_data` to slot `wr_idx` (0..7) and increments `wr_idx`.
  - The accept at `wr_idx`=7 moves the FSM to COMPUTE.
  - `flush`=1 clears `wr_idx` to 0 and discards the partial frame. A simultaneous accept in the same cycle is dropped.
- COMPUTE:
  - `in_ready`=0 and `fft_en`=1.
  - `fft_x0..7` drive slots 0..7 directly from registers and stay stable.
  - The latency counter counts 0..FFT_LAT. On the cycle the count equals FFT_LAT, all 16 core outputs are captured into result registers and the FSM moves to DRAIN.
- DRAIN:
  - `out_valid`=1 and `fft_en`=0.
  - `out_re`/`out_im`/`out_idx` show result `rd_idx`. `out_last`=(`rd_idx`==7).
  - Each `out_valid&&out_ready` increments `rd_idx`.
  - Accepting bin 7 moves the FSM to FILL, clears `wr_idx`/`rd_idx` and increments `frame_cnt`.
- Outputs hold stable while `out_valid`=1 and `out_ready`=0. No frame overlap: the next frame is not accepted until the drain completes.
- `flush` is ignored in COMPUTE and DRAIN.
- No arithmetic on data; values pass bit-exact. The core sees slot k as `x_k`.

## Timing

- Reset values (asynchronous): FSM=FILL, `in_ready`=1, `out_valid`=0, `out_last`=0, `out_idx`=0, `out_re`/`out_im`=0, `fft_x*`=0, `fft_en`=0, `busy`=0, `frame_cnt`=0. Reset mid-frame discards all data; no output follows.
- The cycle after the 8th input accept, `fft_en`=1 and `busy`=1.
- `fft_en` is high for exactly FFT_LAT+1 cycles.
- First `out_valid` appears FFT_LAT+2 cycles after the 8th accept.
- With `out_ready` held high, 8 bins take 8 consecutive cycles. `in_ready` rises the cycle after bin 7 is accepted.
- Minimum frame period with both sides always ready: 8 + (FFT_LAT+1) + 8 cycles.
- All outputs are registered except `in_ready` and `out_last`, which are decoded from registered state.

## Structure

- Package `fft8_pkg`: `N`=8, `IDX_W`=3, state enum {FILL, COMPUTE, DRAIN}.
- One sub-module, `fft8_frame_buf`: an 8×W register file with indexed write and parallel read. Two instances are used, one for input samples and one for the re/im results (2W width).
- FSM, counters and handshake logic sit in the top level.

## Test plan

- **Basic frame.** Bench stub core with FFT_LAT=3 returns `r_k`=k+1, `i_k`=-(k+1). Send 256,384,512,640,64896,65024,65152,65280 → `fft_x0..7` equal those values; `fft_en` high for 4 cycles; bins 0..7 stream out as (1,0xFFFF)…(8,0xFFF8); `out_last` on bin 7; `frame_cnt`=1.
- **Backpressure.** Toggle `out_ready` 1,0,0,1 repeatedly → no bin is lost or duplicated; outputs are stable while stalled; `in_ready`=0 until bin 7 is accepted.
- **Input gaps.** `in_valid` random at 30% → the frame still assembles in order. Check the exact cycle of `fft_en` rise relative to the 8th accept.
- **Flush.** Send 5 samples, then `flush`=1 in the same cycle as `in_valid`=1 → that sample is dropped. The next 8 samples form the frame and appear on `fft_x0..7`.
- **Reset mid-operation.** Assert `rst`=0 during DRAIN at bin 3 → all outputs immediately take their reset values. After release, a full frame works and `frame_cnt` counts from 0.
- **Wrap.** Force `frame_cnt` to 0xFFFF and complete a frame → `frame_cnt`=0.

Source files
------------

// File: rtl/fft8_pkg.sv
// fft8_pkg: shared constants and types for the 8-point FFT frame sequencer.
//   N      - points per frame
//   IDX_W  - width of a slot/bin index
//   state_e - sequencer phases: FILL (collect samples), COMPUTE (core running),
//             DRAIN (stream bins out)
package fft8_pkg;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/fft8_frame_buf.sv
// fft8_frame_buf: N x W register file with one indexed write port, one
// whole-array load port and a parallel read of every entry.
//   clk, rst_n     - clock, asynchronous active-low reset (contents cleared)
//   we/waddr/wdata - indexed write of one entry
//   ld/ldata       - load all entries at once (takes priority over we)
//   rdata          - all entries, registered
module fft8_frame_buf
  import fft8_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  idx_t                waddr,
  input  logic [W-1:0]        wdata,
  input  logic                ld,
  input  logic [N-1:0][W-1:0] ldata,
  output logic [N-1:0][W-1:0] rdata
);

  logic [N-1:0][W-1:0] mem_q, mem_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d = mem_q;
    if (ld) begin
      mem_d = ldata;
    end else if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // NOTE: this storage is reset on purpose - its contents drive the core
  // inputs, which must read zero out of reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q;

endmodule

// File: rtl/fft8_frame_sequencer.sv
// fft8_frame_sequencer: streaming wrapper around an external 8-point FFT core.
// Collects 8 real samples (in_*), presents them in parallel on fft_x*, holds
// fft_en for FFT_LAT+1 cycles, captures fft_r*/fft_i* and streams the 8 bins
// out (out_*) one per handshake.
//   clk, rst        - clock, asynchronous active-low reset
//   in_valid/in_ready/in_data          - sample input handshake
//   out_valid/out_ready/out_re/out_im/out_idx/out_last - bin output handshake
//   flush           - drop a partial frame (only honoured while filling)
//   fft_x0..7, fft_en                  - to the core
//   fft_r0..7, fft_i0..7               - from the core
//   busy            - computing or draining
//   frame_cnt       - completed frames, wraps
module fft8_frame_sequencer
  import fft8_pkg::*;
#(
  parameter int W       = 16,
  parameter int FFT_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [2:0]   out_idx,
  output logic         out_last,
  input  logic         flush,
  output logic [W-1:0] fft_x0, fft_x1, fft_x2, fft_x3,
  output logic [W-1:0] fft_x4, fft_x5, fft_x6, fft_x7,
  output logic         fft_en,
  input  logic [W-1:0] fft_r0, fft_r1, fft_r2, fft_r3,
  input  logic [W-1:0] fft_r4, fft_r5, fft_r6, fft_r7,
  input  logic [W-1:0] fft_i0, fft_i1, fft_i2, fft_i3,
  input  logic [W-1:0] fft_i4, fft_i5, fft_i6, fft_i7,
  output logic         busy,
  output logic [15:0]  frame_cnt
);

  state_e        state_q, state_d;
  idx_t          wr_idx_q, wr_idx_d;
  idx_t          rd_idx_q, rd_idx_d;
  logic [3:0]    lat_q, lat_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_re_q, out_re_d;
  logic [W-1:0]  out_im_q, out_im_d;
  logic          fft_en_q, fft_en_d;
  logic          busy_q, busy_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic                    in_accept, out_accept, capture, last_bin;
  logic [N-1:0][W-1:0]     smp_rdata;
  logic [N-1:0][2*W-1:0]   res_ldata, res_rdata;
  logic [2*W-1:0]          res_next;

  // flush wins over a same-cycle sample, which is dropped.
  assign in_accept  = (state_q == FILL) && in_valid && !flush;
  assign out_accept = out_valid_q && out_ready;
  assign capture    = (state_q == COMPUTE) && (lat_q == 4'(FFT_LAT));
  assign last_bin   = (rd_idx_q == idx_t'(N-1));

  assign res_ldata[0] = {fft_r0, fft_i0};
  assign res_ldata[1] = {fft_r1, fft_i1};
  assign res_ldata[2] = {fft_r2, fft_i2};
  assign res_ldata[3] = {fft_r3, fft_i3};
  assign res_ldata[4] = {fft_r4, fft_i4};
  assign res_ldata[5] = {fft_r5, fft_i5};
  assign res_ldata[6] = {fft_r6, fft_i6};
  assign res_ldata[7] = {fft_r7, fft_i7};

  fft8_frame_buf #(.W(W)) u_smp_buf (
    .clk   (clk),
    .rst_n (rst),
    .we    (in_accept),
    .waddr (wr_idx_q),
    .wdata (in_data),
    .ld    (1'b0),
    .ldata ('0),
    .rdata (smp_rdata)
  );

  fft8_frame_buf #(.W(2*W)) u_res_buf (
    .clk   (clk),
    .rst_n (rst),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .ld    (capture),
    .ldata (res_ldata),
    .rdata (res_rdata)
  );

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      lat_q       <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      fft_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      lat_q       <= lat_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      fft_en_q    <= fft_en_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (in_accept && (wr_idx_q == idx_t'(N-1))) state_d = COMPUTE;
      COMPUTE: if (capture) state_d = DRAIN;
      DRAIN:   if (out_accept && last_bin) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Counters and registered outputs, computed from the next state so they
  // line up with the phase they describe.
  assign res_next = res_rdata[rd_idx_q + idx_t'(1)];

  always_comb begin
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    lat_d       = '0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    frame_cnt_d = frame_cnt_q;

    if (state_q == FILL) begin
      // Index wraps 7 -> 0 on the final accept, ready for the next frame.
      if (flush)          wr_idx_d = '0;
      else if (in_accept) wr_idx_d = wr_idx_q + idx_t'(1);
    end

    if (state_q == COMPUTE) lat_d = lat_q + 4'd1;

    if (capture) begin
      // Bin 0 comes straight from the core so it is valid on the first
      // DRAIN cycle, the same edge the result buffer loads.
      out_re_d = fft_r0;
      out_im_d = fft_i0;
      rd_idx_d = '0;
    end else if (out_accept) begin
      rd_idx_d = rd_idx_q + idx_t'(1);
      if (last_bin) begin
        out_re_d    = '0;
        out_im_d    = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        out_re_d = res_next[2*W-1:W];
        out_im_d = res_next[W-1:0];
      end
    end

    out_valid_d = (state_d == DRAIN);
    fft_en_d    = (state_d == COMPUTE);
    busy_d      = (state_d != FILL);
  end

  // Decoded outputs.
  always_comb begin
    in_ready = (state_q == FILL);
    out_last = out_valid_q && last_bin;
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = rd_idx_q;
  assign fft_en    = fft_en_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

  assign fft_x0 = smp_rdata[0];
  assign fft_x1 = smp_rdata[1];
  assign fft_x2 = smp_rdata[2];
  assign fft_x3 = smp_rdata[3];
  assign fft_x4 = smp_rdata[4];
  assign fft_x5 = smp_rdata[5];
  assign fft_x6 = smp_rdata[6];
  assign fft_x7 = smp_rdata[7];

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// tb_fft8_frame_sequencer: randomized self-checking bench with a stub FFT core
// whose outputs are only meaningful FFT_LAT enabled cycles after fft_en rises.
module tb_fft8_frame_sequencer;
  localparam int W   = 16;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, out_last, fft_en, busy;
  logic [W-1:0] out_re, out_im;
  logic [2:0]   out_idx;
  logic [15:0]  frame_cnt;
  logic [W-1:0] fft_x [8];
  logic [W-1:0] fft_r [8];
  logic [W-1:0] fft_i [8];

  fft8_frame_sequencer #(.W(W), .FFT_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .flush(flush),
    .fft_x0(fft_x[0]), .fft_x1(fft_x[1]), .fft_x2(fft_x[2]), .fft_x3(fft_x[3]),
    .fft_x4(fft_x[4]), .fft_x5(fft_x[5]), .fft_x6(fft_x[6]), .fft_x7(fft_x[7]),
    .fft_en(fft_en),
    .fft_r0(fft_r[0]), .fft_r1(fft_r[1]), .fft_r2(fft_r[2]), .fft_r3(fft_r[3]),
    .fft_r4(fft_r[4]), .fft_r5(fft_r[5]), .fft_r6(fft_r[6]), .fft_r7(fft_r[7]),
    .fft_i0(fft_i[0]), .fft_i1(fft_i[1]), .fft_i2(fft_i[2]), .fft_i3(fft_i[3]),
    .fft_i4(fft_i[4]), .fft_i5(fft_i[5]), .fft_i6(fft_i[6]), .fft_i7(fft_i[7]),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  // Stub core: garbage until fft_en has been high LAT clocks.
  // mode 0: r_k = k+1, i_k = -(k+1); mode 1: r_k = x_(7-k), i_k = ~x_k.
  int stub_en_cnt;
  bit stub_mode = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) stub_en_cnt <= 0;
    else      stub_en_cnt <= fft_en ? stub_en_cnt + 1 : 0;
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      fft_r[k] = 16'hBAD0;
      fft_i[k] = 16'hBAD1;
      if (stub_en_cnt >= LAT) begin
        fft_r[k] = stub_mode ? fft_x[7-k] : 16'(k + 1);
        fft_i[k] = stub_mode ? ~fft_x[k]  : 16'(-(k + 1));
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_fft_en", fft_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    for (int k = 0; k < 8; k++) check("rst_fft_x", fft_x[k], 0);
  endtask

  // One frame end-to-end. vpct: in_valid probability; rmode: 0 always ready,
  // 1 pattern 1,0,0,1, 2 random; flush_at: flush once after that many samples
  // (-1 none); abort_bin: assert reset when this bin is presented (-1 none).
  task automatic run_frame(input int vpct, input int rmode, input int flush_at,
                           input int abort_bin, input bit use_fixed,
                           input logic [W-1:0] fixed [8]);
    logic [W-1:0] q[$];
    logic [W-1:0] exp_re [8];
    logic [W-1:0] exp_im [8];
    logic [W-1:0] d;
    bit v, fl, flushed, rdy;
    int guard, en_len, rd, cyc;
    bit pat [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    flushed = 0;
    guard = 0;

    while (q.size() < 8 && guard < 2000) begin
      @(negedge clk);
      guard++;
      check("fill_in_ready", in_ready, 1);
      check("fill_fft_en", fft_en, 0);
      check("fill_out_valid", out_valid, 0);
      v  = ($urandom_range(99) < vpct);
      fl = 0;
      if (flush_at >= 0 && !flushed && q.size() == flush_at) begin
        fl = 1; v = 1; flushed = 1;
      end
      d = use_fixed ? fixed[q.size()] : 16'($urandom);
      in_valid = v; in_data = d; flush = fl;
      if (fl) q.delete();
      else if (v) q.push_back(d);
    end
    if (q.size() < 8) begin
      check("fill_timeout", 0, 1);
      return;
    end

    // Cycle right after the 8th accept.
    @(negedge clk);
    in_valid = 0; flush = 0;
    check("post_accept_fft_en", fft_en, 1);
    check("post_accept_busy", busy, 1);
    check("post_accept_in_ready", in_ready, 0);
    for (int k = 0; k < 8; k++) check("fft_x", fft_x[k], q[k]);

    en_len = 1;
    while (en_len < 40) begin
      @(negedge clk);
      // flush must be ignored outside FILL
      flush = 1'($urandom_range(1));
      if (!fft_en) break;
      en_len++;
      for (int k = 0; k < 8; k++) check("fft_x_stable", fft_x[k], q[k]);
    end
    check("fft_en_len", en_len, LAT + 1);
    check("first_out_valid", out_valid, 1);

    for (int k = 0; k < 8; k++) begin
      exp_re[k] = stub_mode ? q[7-k] : 16'(k + 1);
      exp_im[k] = stub_mode ? ~q[k]  : 16'(-(k + 1));
    end

    rd = 0; cyc = 0;
    while (rd < 8 && cyc < 200) begin
      check("drain_out_valid", out_valid, 1);
      check("drain_out_idx", out_idx, rd);
      check("drain_out_re", out_re, exp_re[rd]);
      check("drain_out_im", out_im, exp_im[rd]);
      check("drain_out_last", out_last, (rd == 7));
      check("drain_in_ready", in_ready, 0);
      check("drain_busy", busy, 1);
      if (abort_bin == rd) begin
        rst = 0; out_ready = 0; flush = 0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1;
        exp_cnt = '0;
        return;
      end
      case (rmode)
        0:       rdy = 1;
        1:       rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(1));
      endcase
      out_ready = rdy;
      if (rdy) rd++;
      cyc++;
      @(negedge clk);
    end
    if (rd < 8) check("drain_timeout", 0, 1);
    out_ready = 0; flush = 0;
    exp_cnt = exp_cnt + 16'd1;
    check("end_out_valid", out_valid, 0);
    check("end_in_ready", in_ready, 1);
    check("end_busy", busy, 0);
    check("end_frame_cnt", frame_cnt, exp_cnt);
  endtask

  logic [W-1:0] basic_x [8] = '{16'd256, 16'd384, 16'd512, 16'd640,
                                16'd64896, 16'd65024, 16'd65152, 16'd65280};

  initial begin
    repeat (2) @(negedge clk);
    check_reset_values();
    rst = 1;

    // Basic frame with constant stub results.
    stub_mode = 0;
    run_frame(100, 0, -1, -1, 1'b1, basic_x);

    // Data-dependent stub from here on.
    stub_mode = 1;
    for (int i = 0; i < 2; i++) run_frame(100, 1, -1, -1, 1'b0, basic_x);
    for (int i = 0; i < 3; i++) run_frame(30, 2, -1, -1, 1'b0, basic_x);

    // Flush after 5 samples, with a same-cycle sample that must be dropped.
    run_frame(60, 0, 5, -1, 1'b0, basic_x);

    // Reset during drain at bin 3, then a clean frame counting from zero.
    run_frame(100, 0, -1, 3, 1'b0, basic_x);
    run_frame(100, 2, -1, -1, 1'b0, basic_x);

    // Counter wrap.
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    @(negedge clk);
    check("wrap_preset", frame_cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    run_frame(100, 0, -1, -1, 1'b0, basic_x);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
